// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: holds MEM-stage results and WB control bits for one
// pipeline cycle, built from enable/async-reset flip-flop primitives.

module D_FlipFlop (
  output logic q,
  input  logic d,
  input  logic en,
  input  logic reset,
  input  logic clk
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// One flip-flop per bit; the width defaults to the name so the 32-bit
// datapath can still be narrowed through the top-level parameter.
module register_5 #(
  parameter int W = 5
) (
  output logic [W-1:0] q,
  input  logic [W-1:0] d,
  input  logic         en,
  input  logic         reset,
  input  logic         clk
);
  for (genvar gi = 0; gi < W; gi++) begin : gBit
    D_FlipFlop uFf (.q(q[gi]), .d(d[gi]), .en(en), .reset(reset), .clk(clk));
  end
endmodule

module register_32 #(
  parameter int W = 32
) (
  output logic [W-1:0] q,
  input  logic [W-1:0] d,
  input  logic         en,
  input  logic         reset,
  input  logic         clk
);
  for (genvar gi = 0; gi < W; gi++) begin : gBit
    D_FlipFlop uFf (.q(q[gi]), .d(d[gi]), .en(en), .reset(reset), .clk(clk));
  end
endmodule

module mem_wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [DATA_W-1:0] memDataIn,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [REG_W-1:0]  writeRegIn,
  input  logic              regWriteIn,
  input  logic              memToRegIn,
  output logic [DATA_W-1:0] memDataOut,
  output logic [DATA_W-1:0] aluResultOut,
  output logic [REG_W-1:0]  writeRegOut,
  output logic              regWriteOut,
  output logic              memToRegOut
);
  // Every field shares the same enable, so a stall freezes the whole stage.
  register_32 #(.W(DATA_W)) uMemData (
    .q(memDataOut), .d(memDataIn), .en(write), .reset(reset), .clk(clk)
  );

  register_32 #(.W(DATA_W)) uAluResult (
    .q(aluResultOut), .d(aluResultIn), .en(write), .reset(reset), .clk(clk)
  );

  register_5 #(.W(REG_W)) uWriteReg (
    .q(writeRegOut), .d(writeRegIn), .en(write), .reset(reset), .clk(clk)
  );

  D_FlipFlop uRegWrite (
    .q(regWriteOut), .d(regWriteIn), .en(write), .reset(reset), .clk(clk)
  );

  D_FlipFlop uMemToReg (
    .q(memToRegOut), .d(memToRegIn), .en(write), .reset(reset), .clk(clk)
  );
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: expected outputs are queued when an edge
// (or a reset event) is applied and compared once the DUT has responded.

module tb_mem_wb_pipe_reg;
  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [31:0] memDataIn, aluResultIn;
  logic [4:0]  writeRegIn;
  logic        regWriteIn, memToRegIn;
  logic [31:0] memDataOut, aluResultOut;
  logic [4:0]  writeRegOut;
  logic        regWriteOut, memToRegOut;

  typedef struct packed {
    logic [31:0] md;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
  } exp_t;

  exp_t expQ[$];
  exp_t model;
  int checks = 0;
  int errors = 0;
  int txn = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_reg dut (
    .clk(clk), .reset(reset), .write(write),
    .memDataIn(memDataIn), .aluResultIn(aluResultIn), .writeRegIn(writeRegIn),
    .regWriteIn(regWriteIn), .memToRegIn(memToRegIn),
    .memDataOut(memDataOut), .aluResultOut(aluResultOut), .writeRegOut(writeRegOut),
    .regWriteOut(regWriteOut), .memToRegOut(memToRegOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Pop one expectation and compare every output field against it.
  task automatic popCompare(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    txn++;
    $display("txn %0d %s md=%h alu=%h wr=%0d rw=%b m2r=%b", txn, tag,
             memDataOut, aluResultOut, writeRegOut, regWriteOut, memToRegOut);
    check({tag, ".memData"},   memDataOut,          e.md);
    check({tag, ".aluResult"}, aluResultOut,        e.alu);
    check({tag, ".writeReg"},  {27'd0, writeRegOut}, {27'd0, e.wr});
    check({tag, ".regWrite"},  {31'd0, regWriteOut}, {31'd0, e.rw});
    check({tag, ".memToReg"},  {31'd0, memToRegOut}, {31'd0, e.m2r});
  endtask

  // Apply one rising edge: update the reference state from the inputs now
  // present, queue it, then sample just after the edge.
  task automatic edgeStep(input string tag);
    if (!reset) model = '0;
    else if (write) model = '{memDataIn, aluResultIn, writeRegIn, regWriteIn, memToRegIn};
    expQ.push_back(model);
    @(posedge clk);
    #1;
    popCompare(tag);
  endtask

  task automatic setIn(input logic w, input logic [31:0] md, input logic [31:0] alu,
                       input logic [4:0] wr, input logic rw, input logic m2r);
    write = w; memDataIn = md; aluResultIn = alu;
    writeRegIn = wr; regWriteIn = rw; memToRegIn = m2r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model = '0;
    reset = 1'b0;
    setIn(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 1'b1, 1'b1);
    #1;
    expQ.push_back('0);
    popCompare("rst.initial");

    // Reset held with write=1 and varying inputs: outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      setIn(1'b1, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
      edgeStep("rst.hold");
    end
    reset = 1'b1;
    setIn(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 5'd9, 1'b1, 1'b1);
    edgeStep("rst.release");

    // First capture, and not visible before its edge.
    setIn(1'b1, 32'd0, 32'd4, 5'd5, 1'b0, 1'b1);
    #2;
    expQ.push_back(model);
    popCompare("cap.before");
    edgeStep("cap.first");

    // Stall: three edges with write=0 and new inputs.
    setIn(1'b0, 32'd0, 32'hDEAD_BEEF, 5'd31, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) edgeStep("stall");

    // Bit-exact copy of extreme patterns, then all zeros.
    setIn(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 5'd31, 1'b1, 1'b0);
    edgeStep("cap.ones");
    setIn(1'b1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    edgeStep("cap.zeros");

    // Asynchronous reset mid-cycle clears before the next edge.
    setIn(1'b1, 32'hCAFE_F00D, 32'h0BAD_C0DE, 5'd22, 1'b1, 1'b1);
    edgeStep("cap.load");
    #2;
    reset = 1'b0;
    #1;
    model = '0;
    expQ.push_back(model);
    popCompare("rst.async");
    setIn(1'b1, 32'h1111_2222, 32'h3333_4444, 5'd7, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) edgeStep("rst.dominate");
    reset = 1'b1;
    setIn(1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd10, 1'b0, 1'b1);
    edgeStep("cap.after_rst");

    // Inputs toggling between edges: only the value present at the edge counts.
    for (int i = 0; i < 6; i++) begin
      setIn(1'b1, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
      #2;
      expQ.push_back(model);
      popCompare("toggle.mid");
      setIn(1'b1, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
      edgeStep("toggle.edge");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
